// File: rtl/reset_seq_pkg.sv
// Shared state encoding and parameter defaults for the reset sequencer.
// Imported by the interface, the debouncer and the top.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam int LOCK_STABLE_DEF  = 1024;
  localparam int RESET_HOLD_DEF   = 256;
  localparam int DEBOUNCE_DEF     = 65536;
  localparam int LOCK_TIMEOUT_DEF = 1048576;

  localparam logic [7:0] LOSS_MAX = 8'hFF;

endpackage

// File: rtl/reset_sequencer_if.sv
// Sequencer-side bundle: PLL lock and button in, reset/status out.
// master = sequencer, slave = consumer/stimulus side.
interface reset_sequencer_if;
  import reset_seq_pkg::*;

  logic       pll_locked;
  logic       ext_rst_n_in;
  logic       sys_rst;
  logic       ready;
  seq_state_t seq_state;
  logic [7:0] lock_loss_count;
  logic       lock_timeout;

  modport master (
    input  pll_locked,
    input  ext_rst_n_in,
    output sys_rst,
    output ready,
    output seq_state,
    output lock_loss_count,
    output lock_timeout
  );

  modport slave (
    output pll_locked,
    output ext_rst_n_in,
    input  sys_rst,
    input  ready,
    input  seq_state,
    input  lock_loss_count,
    input  lock_timeout
  );

endinterface

// File: rtl/rst_debounce.sv
// Button path: 2FF synchronizer then debouncer.
// Ports: clock_in, rst_n_in, button_n (raw, active-low), level_n (debounced).
module rst_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clock_in,
  input  logic rst_n_in,
  input  logic button_n,
  output logic level_n
);

  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         sync1;
  logic         sync2;
  logic [W-1:0] cnt;

  // cnt counts consecutive samples that disagree with the
  // current level; any agreeing sample restarts it.
  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      level_n <= 1'b1;
    end else begin
      sync1 <= button_n;
      sync2 <= sync1;
      if (sync2 == level_n) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_n <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on/button reset sequencer: waits for stable PLL lock, holds reset.
// Ports: clock_in, rst_n_in, bus (master: lock/button in, reset/status out).
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_DEF,
  parameter int RESET_HOLD_CYCLES   = RESET_HOLD_DEF,
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_DEF,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_DEF
) (
  input  logic              clock_in,
  input  logic              rst_n_in,
  reset_sequencer_if.master bus
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES);
  localparam int HW = $clog2(RESET_HOLD_CYCLES);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_t    state, state_d;
  logic [SW-1:0] stb_cnt, stb_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic [7:0]    loss_cnt, loss_d;
  logic          tmo_flag, tmo_flag_d;
  logic          sys_rst_q;
  logic          ready_q;
  logic          btn_level_n;
  logic          pressed;
  logic          locked;
  logic          lost;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock_in(clock_in),
    .rst_n_in(rst_n_in),
    .button_n(bus.ext_rst_n_in),
    .level_n (btn_level_n)
  );

  assign pressed = ~btn_level_n;
  assign locked  = bus.pll_locked;

  always_comb begin
    state_d    = state;
    stb_d      = stb_cnt;
    hold_d     = hold_cnt;
    tmo_d      = tmo_cnt;
    loss_d     = loss_cnt;
    tmo_flag_d = tmo_flag;
    lost       = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        // Timeout counter saturates; the flag is sticky.
        if (tmo_cnt == TMO_LAST) begin
          tmo_flag_d = 1'b1;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
        if (!locked) begin
          stb_d = '0;
        end else if (stb_cnt == STB_LAST) begin
          state_d = HOLD;
          stb_d   = '0;
          tmo_d   = '0;
          hold_d  = '0;
        end else begin
          stb_d = stb_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!locked) begin
          lost = 1'b1;
        end else if (pressed) begin
          hold_d = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked) begin
          lost = 1'b1;
        end else if (pressed) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Lock loss overrides any button activity on the same edge.
    if (lost) begin
      state_d = WAIT_LOCK;
      stb_d   = '0;
      tmo_d   = '0;
      hold_d  = '0;
      if (loss_cnt != LOSS_MAX) begin
        loss_d = loss_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= WAIT_LOCK;
      stb_cnt   <= '0;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      loss_cnt  <= '0;
      tmo_flag  <= 1'b0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_d;
      stb_cnt   <= stb_d;
      hold_cnt  <= hold_d;
      tmo_cnt   <= tmo_d;
      loss_cnt  <= loss_d;
      tmo_flag  <= tmo_flag_d;
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign bus.seq_state       = state;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.lock_loss_count = loss_cnt;
  assign bus.lock_timeout    = tmo_flag;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed steps plus random stimulus
// checked against a timestamp-based behavioural model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int S = 8;
  localparam int H = 4;
  localparam int D = 3;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  reset_sequencer_if bus();

  reset_sequencer #(
    .LOCK_STABLE_CYCLES (S),
    .RESET_HOLD_CYCLES  (H),
    .DEBOUNCE_CYCLES    (D),
    .LOCK_TIMEOUT_CYCLES(T)
  ) dut (
    .clock_in(clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: edge index n since reset release, state 0/1/2,
  // and timestamps of the events that govern each transition.
  int n;
  int m_state;
  int m_loss;
  int m_tmo;
  int wait_entry;
  int run_start;
  int hold_since;
  bit m_deb;
  bit raw_q[$];
  bit seen_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    n = 0;
    m_state = 0;
    m_loss = 0;
    m_tmo = 0;
    wait_entry = 1;
    run_start = 1;
    hold_since = 0;
    m_deb = 1'b1;
    raw_q = '{1'b1, 1'b1};
    seen_q = {};
  endtask

  task automatic model_edge(bit lk, bit btn);
    bit pr;
    bit seen;
    bit same;
    n++;
    pr = !m_deb;
    if (m_state == 0) begin
      if (n - wait_entry + 1 >= T) m_tmo = 1;
      if (!lk) run_start = n + 1;
      else if (n - run_start + 1 == S) begin
        m_state = 1;
        hold_since = n + 1;
      end
    end else if (!lk) begin
      m_state = 0;
      if (m_loss < 255) m_loss++;
      wait_entry = n + 1;
      run_start = n + 1;
    end else if (pr) begin
      m_state = 1;
      hold_since = n + 1;
    end else if (m_state == 1 && n - hold_since + 1 == H) begin
      m_state = 2;
    end
    // Button reaches the debouncer two edges late.
    raw_q.push_back(btn);
    seen = raw_q.pop_front();
    seen_q.push_back(seen);
    if (seen_q.size() > D) void'(seen_q.pop_front());
    if (seen_q.size() == D) begin
      same = 1'b1;
      foreach (seen_q[i]) if (seen_q[i] != seen) same = 1'b0;
      if (same && seen != m_deb) m_deb = seen;
    end
  endtask

  task automatic chk_model();
    string t;
    t = $sformatf("e%0d", n);
    chk({t, ".state"}, bus.seq_state, m_state);
    chk({t, ".sys_rst"}, bus.sys_rst, (m_state != 2));
    chk({t, ".ready"}, bus.ready, (m_state == 2));
    chk({t, ".loss"}, bus.lock_loss_count, m_loss);
    chk({t, ".tmo"}, bus.lock_timeout, m_tmo);
  endtask

  task automatic step(bit lk, bit btn);
    bus.pll_locked = lk;
    bus.ext_rst_n_in = btn;
    @(posedge clk);
    model_edge(lk, btn);
    #1;
    chk_model();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, ".state"}, bus.seq_state, 0);
    chk({tag, ".sys_rst"}, bus.sys_rst, 1);
    chk({tag, ".ready"}, bus.ready, 0);
    chk({tag, ".loss"}, bus.lock_loss_count, 0);
    chk({tag, ".tmo"}, bus.lock_timeout, 0);
  endtask

  // Pulse rst_n_in low strictly between clock edges.
  task automatic apply_reset(string tag);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals(tag);
    #2 rst_n = 1'b1;
    mreset();
  endtask

  initial begin
    bit b;
    bus.pll_locked = 1'b0;
    bus.ext_rst_n_in = 1'b1;
    rst_n = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    #2 rst_n = 1'b1;

    // Nominal lock: HOLD at edge 8, RUN at edge 12.
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      if (i == 7) chk("nom.e7_wait", bus.seq_state, 0);
      if (i == 8) chk("nom.e8_hold", bus.seq_state, 1);
      if (i == 11) chk("nom.e11_rst", bus.sys_rst, 1);
      if (i == 12) begin
        chk("nom.e12_run", bus.seq_state, 2);
        chk("nom.e12_rst", bus.sys_rst, 0);
        chk("nom.e12_rdy", bus.ready, 1);
      end
    end

    // Button held 10 edges, released, back to RUN 4 edges later.
    for (int i = 1; i <= 22; i++) begin
      step(1'b1, (i > 10));
      if (i == 5) chk("btn.e5_rst", bus.sys_rst, 0);
      if (i == 6) chk("btn.e6_rst", bus.sys_rst, 1);
      if (i == 18) chk("btn.e18_rst", bus.sys_rst, 1);
      if (i == 19) chk("btn.e19_rst", bus.sys_rst, 0);
    end

    // One-edge glitch is filtered.
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      chk("glitch.run", bus.seq_state, 2);
    end

    // Lock loss and press on the same edge: loss wins once.
    step(1'b0, 1'b0);
    chk("both.state", bus.seq_state, 0);
    chk("both.loss", bus.lock_loss_count, 1);
    repeat (6) step(1'b1, 1'b1);

    // Random lock/button activity.
    b = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) b = ~b;
      step(($urandom_range(0, 39) != 0), b);
    end

    // Force more than 255 losses: count saturates.
    for (int k = 0; k < 300; k++) begin
      repeat (S + $urandom_range(0, 5))
        step(1'b1, ($urandom_range(0, 7) != 0));
      step(1'b0, 1'b1);
    end
    chk("sat.loss", bus.lock_loss_count, 255);

    // Lock glitch restarts the stable count.
    apply_reset("rst.a");
    repeat (5) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      if (i == 11) chk("glitch_lk.e11", bus.sys_rst, 1);
      if (i == 12) chk("glitch_lk.e12", bus.sys_rst, 0);
    end

    // Lock never arrives: sticky timeout at edge 64.
    apply_reset("rst.b");
    for (int i = 1; i <= 70; i++) begin
      step(1'b0, 1'b1);
      if (i == 63) chk("tmo.e63", bus.lock_timeout, 0);
      if (i == 64) chk("tmo.e64", bus.lock_timeout, 1);
    end
    repeat (12) step(1'b1, 1'b1);
    chk("tmo.run", bus.seq_state, 2);
    chk("tmo.sticky", bus.lock_timeout, 1);

    // Async reset mid-HOLD clears everything immediately.
    step(1'b0, 1'b1);
    repeat (9) step(1'b1, 1'b1);
    chk("mid.hold", bus.seq_state, 1);
    chk("mid.loss", bus.lock_loss_count, 1);
    apply_reset("rst.c");
    repeat (12) step(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
